// File: rtl/qif_sweep_if.sv
// qif_sweep_if: host/consumer bundle of the QIF sweep scheduler (tick, B config, spike stream, status)
// Ports (signals): tick, cfg_we, cfg_addr, cfg_b, spk_ready driven by the host (master);
//                  spk_valid, spk_id, v_out, v_id, busy, done, overrun driven by the scheduler (slave).
interface qif_sweep_if #(parameter int AW = 2);
    logic          tick, cfg_we, spk_ready;
    logic [AW-1:0] cfg_addr;
    logic [7:0]    cfg_b;
    logic          spk_valid, busy, done, overrun;
    logic [AW-1:0] spk_id, v_id;
    logic [7:0]    v_out;
    modport master (
        output tick, cfg_we, cfg_addr, cfg_b, spk_ready,
        input  spk_valid, spk_id, v_out, v_id, busy, done, overrun
    );
    modport slave (
        input  tick, cfg_we, cfg_addr, cfg_b, spk_ready,
        output spk_valid, spk_id, v_out, v_id, busy, done, overrun
    );
endinterface

// File: rtl/qif_sweep_scheduler.sv
// qif_sweep_scheduler: one QIF membrane-update datapath time-multiplexed over N virtual neurons
// Ports: clk; rst (synchronous, active-low); bus (qif_sweep_if.slave) carrying tick, cfg_we/cfg_addr/cfg_b,
//        spk_valid/spk_ready/spk_id, v_out/v_id, busy, done, overrun.
// Option: define QIF_REFRACTORY_EN to hold a neuron at VRESET for REFR sweeps after each spike.
module qif_sweep_scheduler #(
    parameter int         N      = 4,
    parameter int         AW     = 2,
    parameter logic [7:0] THRESH = 8'd200,
    parameter logic [7:0] VRESET = 8'd0,
    parameter int         QSHIFT = 6,
    parameter int         REFR   = 2
) (
    input logic        clk,
    input logic        rst,
    qif_sweep_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, UPDATE, EMIT} state_t;
    state_t        state, state_n;
    logic [AW-1:0] idx, spk_id, v_id;
    logic [7:0]    v_mem [N];
    logic [7:0]    b_mem [N];
    logic [7:0]    v_lat, b_lat, v_new, v_out;
    logic [16:0]   v_ext, sum;
    logic          hold, spike, last, adv, done, overrun;

    // 17-bit sum cannot wrap: 255 + (255*255 >> QSHIFT) + 255 stays well inside it
    assign v_ext = {9'd0, v_lat};
    assign sum   = v_ext + ((v_ext * v_ext) >> QSHIFT) + {9'd0, b_lat};
    assign spike = !hold && sum >= {9'd0, THRESH};
    assign v_new = (spike || hold) ? VRESET : sum[7:0];
    assign last  = idx == AW'(N - 1);
    assign adv   = (state == UPDATE && !spike) || (state == EMIT && bus.spk_ready);

`ifdef QIF_REFRACTORY_EN
    localparam int CW = REFR > 0 ? $clog2(REFR + 1) : 1;
    logic [CW-1:0] cnt [N];
    assign hold = cnt[idx] != '0;
    always_ff @(posedge clk) begin
        if (!rst)
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        else if (state == UPDATE)
            cnt[idx] <= hold ? cnt[idx] - CW'(1) : spike ? CW'(REFR) : cnt[idx];
    end
`else
    // never true: without the refractory counter every neuron integrates every sweep
    assign hold = REFR < 0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && bus.tick) state_n = FETCH;
        else if (state == FETCH)        state_n = UPDATE;
        else if (state == UPDATE && spike) state_n = EMIT;
        else if (adv)                   state_n = last ? IDLE : FETCH;
    end

    // B writes land at the same edge FETCH latches, so a same-cycle write to the fetched index is not seen
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx     <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            spk_id  <= '0;
            v_id    <= '0;
            v_out   <= '0;
            v_lat   <= '0;
            b_lat   <= '0;
            for (int i = 0; i < N; i++) begin
                v_mem[i] <= VRESET;
                b_mem[i] <= '0;
            end
        end else begin
            done <= adv && last;
            if (adv) idx <= last ? '0 : idx + AW'(1);
            if (bus.tick && state != IDLE) overrun <= 1'b1;
            if (bus.cfg_we) b_mem[bus.cfg_addr] <= bus.cfg_b;
            if (state == FETCH) begin
                v_lat <= v_mem[idx];
                b_lat <= b_mem[idx];
            end
            if (state == UPDATE) begin
                v_mem[idx] <= v_new;
                v_out      <= v_new;
                v_id       <= idx;
                if (spike) spk_id <= idx;
            end
        end
    end

    assign bus.busy      = state != IDLE;
    assign bus.spk_valid = state == EMIT;
    assign bus.spk_id    = spk_id;
    assign bus.v_out     = v_out;
    assign bus.v_id      = v_id;
    assign bus.done      = done;
    assign bus.overrun   = overrun;
endmodule

// File: tb/tb_qif_sweep_scheduler.sv
// tb_qif_sweep_scheduler: directed and randomized checks of qif_sweep_scheduler against a sweep-level model
module tb_qif_sweep_scheduler;
    localparam int N = 4, THRESH = 200, VRESET = 0, QSHIFT = 6, REFR = 2;
    logic clk = 1'b0, rst = 1'b0;
    bit   chk_en = 1'b0;
    int   n_chk = 0, n_err = 0;

    qif_sweep_if #(.AW(2)) b();
    qif_sweep_scheduler dut (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one procedural sweep per tick ----------------
    int   mv[N], mb[N], mc[N];
    bit   pend_we;
    int   pend_a, pend_b;
    bit   s_tick, s_ready;
    logic e_busy = 0, e_valid = 0, e_done = 0, e_ovr = 0;
    int   e_spk = 0, e_vout = 0, e_vid = 0;

    // advance the model by one clock edge; config writes become visible one edge later
    task automatic tb_edge(output bit r);
        @(posedge clk);
        s_tick  = b.tick;
        s_ready = b.spk_ready;
        e_done  = 0;
        if (!rst) begin
            r = 1;
            pend_we = 0;
            foreach (mv[i]) begin mv[i] = VRESET; mb[i] = 0; mc[i] = 0; end
            e_busy = 0; e_valid = 0; e_ovr = 0; e_spk = 0; e_vout = 0; e_vid = 0;
        end else begin
            r = 0;
            if (pend_we) mb[pend_a] = pend_b;
            pend_we = b.cfg_we;
            pend_a  = int'(b.cfg_addr);
            pend_b  = int'(b.cfg_b);
            if (b.tick && e_busy) e_ovr = 1;
        end
    endtask

    initial begin : ref_model
        bit r;
        bit sp;
        int v, bb, s;
        forever begin
            tb_edge(r);
            if (r || !s_tick) continue;
            e_busy = 1;
            for (int i = 0; i < N; i++) begin
                tb_edge(r);
                if (r) break;
                v  = mv[i];
                bb = mb[i];
                tb_edge(r);
                if (r) break;
                s  = v + ((v * v) >> QSHIFT) + bb;
                sp = 0;
                if (mc[i] != 0) begin
                    mc[i]--;
                    mv[i] = VRESET;
                end else if (s >= THRESH) begin
                    sp = 1;
                    mv[i] = VRESET;
`ifdef QIF_REFRACTORY_EN
                    mc[i] = REFR;
`endif
                end else mv[i] = s % 256;
                e_vout = mv[i];
                e_vid  = i;
                if (sp) begin
                    e_valid = 1;
                    e_spk   = i;
                    do tb_edge(r); while (!r && !s_ready);
                    if (r) break;
                    e_valid = 0;
                end
            end
            if (!r) begin
                e_busy = 0;
                e_done = 1;
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("busy", b.busy, e_busy);
        chk("spk_valid", b.spk_valid, e_valid);
        chk("spk_id", b.spk_id, e_spk);
        chk("done", b.done, e_done);
        chk("overrun", b.overrun, e_ovr);
        chk("v_out", b.v_out, e_vout);
        chk("v_id", b.v_id, e_vid);
    end

    // ---------------- stimulus ----------------
    task automatic cfg(input int a, input int v);
        b.cfg_we = 1; b.cfg_addr = a[1:0]; b.cfg_b = v[7:0];
        @(negedge clk);
        b.cfg_we = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic run_sweep(input bit mid, input int stall, output int cyc, output int spk,
                             output int ids, output int held, output int v1);
        int left;
        left = stall; cyc = 0; spk = 0; ids = 0; held = 0; v1 = -1;
        b.tick = 1;
        @(negedge clk);
        b.tick = 0;
        for (int k = 0; k < 200 && !b.done; k++) begin
            b.tick = mid && k == 3;
            if (b.busy) cyc++;
            if (b.spk_valid) ids |= 1 << b.spk_id;
            if (b.spk_valid && left > 0) begin
                b.spk_ready = 0;
                left--;
                held += int'(b.spk_id == 2'd1);
            end else b.spk_ready = 1;
            if (b.spk_valid && b.spk_ready) spk++;
            if (b.v_id == 2'd1) v1 = int'(b.v_out);
            @(negedge clk);
        end
        b.tick = 0;
        b.spk_ready = 1;
        chk("sweep_done_seen", b.done, 1);
    endtask

    initial begin : stim
        int cyc, spk, ids, held, v1, k;
`ifdef QIF_REFRACTORY_EN
        int exp_s[4] = '{1, 0, 0, 1};
        int exp_c[4] = '{9, 8, 8, 9};
`else
        int exp_s[4] = '{1, 1, 1, 1};
        int exp_c[4] = '{9, 9, 9, 9};
`endif
        b.tick = 0; b.cfg_we = 0; b.cfg_addr = 0; b.cfg_b = 0; b.spk_ready = 1;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("reset_busy", b.busy, 0);
        chk("reset_overrun", b.overrun, 0);
        rst = 1;

        run_sweep(0, 0, cyc, spk, ids, held, v1);
        chk("zero_sweep_cycles", cyc, 8);
        chk("zero_sweep_spikes", spk, 0);
        chk("zero_sweep_v1", v1, 0);

        cfg(1, 50);
        run_sweep(0, 0, cyc, spk, ids, held, v1);
        chk("b50_s1_v1", v1, 50);
        chk("b50_s1_model", mv[1], 50);
        run_sweep(0, 0, cyc, spk, ids, held, v1);
        chk("b50_s2_v1", v1, 139);
        chk("b50_s2_model", mv[1], 139);
        run_sweep(0, 0, cyc, spk, ids, held, v1);
        chk("b50_s3_v1", v1, 0);
        chk("b50_s3_spikes", spk, 1);
        chk("b50_s3_ids", ids, 2);
        chk("b50_s3_cycles", cyc, 9);
        chk("b50_s3_model", mv[1], 0);

        run_sweep(1, 0, cyc, spk, ids, held, v1);
        chk("overrun_sweep_cycles", cyc, 8);
        chk("overrun_set", b.overrun, 1);
        repeat (3) @(negedge clk);
        chk("overrun_sticky", b.overrun, 1);
        do_reset();
        chk("overrun_cleared", b.overrun, 0);

        cfg(1, 250);
        run_sweep(0, 5, cyc, spk, ids, held, v1);
        chk("stall_cycles", cyc, 14);
        chk("stall_held", held, 5);
        chk("stall_spikes", spk, 1);

        do_reset();
        cfg(1, 250);
        b.spk_ready = 0;
        b.tick = 1;
        @(negedge clk);
        b.tick = 0;
        k = 0;
        while (!b.spk_valid && k < 50) begin @(negedge clk); k++; end
        chk("emit_reached", b.spk_valid, 1);
        rst = 0;
        @(negedge clk);
        chk("emit_rst_valid", b.spk_valid, 0);
        chk("emit_rst_busy", b.busy, 0);
        rst = 1;
        b.spk_ready = 1;
        run_sweep(0, 0, cyc, spk, ids, held, v1);
        chk("post_rst_cycles", cyc, 8);
        chk("post_rst_spikes", spk, 0);
        chk("post_rst_v1", v1, 0);

        do_reset();
        cfg(0, 250);
        for (int s = 0; s < 4; s++) begin
            run_sweep(0, 0, cyc, spk, ids, held, v1);
            chk($sformatf("b0_sweep%0d_spikes", s + 1), spk, exp_s[s]);
            chk($sformatf("b0_sweep%0d_cycles", s + 1), cyc, exp_c[s]);
        end

        for (int i = 0; i < 1500; i++) begin
            b.tick      = $urandom % 6 == 0;
            b.cfg_we    = $urandom % 5 == 0;
            b.cfg_addr  = 2'($urandom_range(0, 3));
            b.cfg_b     = 8'($urandom_range(0, 120));
            b.spk_ready = $urandom % 4 != 0;
            rst         = $urandom % 200 != 0;
            @(negedge clk);
        end
        b.tick = 0; b.cfg_we = 0; b.spk_ready = 1; rst = 1;
        repeat (40) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
